// File: rtl/imm_extend_ctrl_if.sv
// Handshake and result bundle for the immediate-extend stage.
// The master side drives the upstream/downstream controls and the slave is the stage itself.
interface imm_extend_ctrl_if;
  logic        In_Valid;
  logic [31:0] In_Instr;
  logic        In_Ready;
  logic        Flush;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Imm;
  logic [2:0]  Out_Mode;
  logic        Illegal;

  modport master (
    output In_Valid, In_Instr, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Out_Imm, Out_Mode, Illegal
  );

  modport slave (
    input  In_Valid, In_Instr, Flush, Out_Ready,
    output In_Ready, Out_Valid, Out_Imm, Out_Mode, Illegal
  );
endinterface

// File: rtl/imm_extend_ctrl.sv
// One-entry registered MIPS immediate-extend stage with valid/ready handshake.
// Define IMM_EXT_UPPER_EN to decode lui (0x0F) as UPPER; otherwise it is ZERO-extended.
//
//   state | meaning
//   EMPTY | no decoded instruction held, Out_Valid=0
//   FULL  | Out_Imm/Out_Mode hold a decoded instruction, Out_Valid=1
module imm_extend_ctrl (
  input  logic               Clk,
  input  logic               Rst_n,
  imm_extend_ctrl_if.slave   bus
);

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_SIGN  = 3'd1;
  localparam logic [2:0] MODE_ZERO  = 3'd2;
  localparam logic [2:0] MODE_UPPER = 3'd3;
  localparam logic [2:0] MODE_SHAMT = 3'd4;
  localparam logic [2:0] MODE_JUMP  = 3'd5;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        out_valid;
  logic        in_ready;
  logic        accept;
  logic [31:0] imm_q;
  logic [2:0]  mode_q;
  logic        illegal_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] dec_imm;
  logic [2:0]  dec_mode;
  logic        dec_illegal;

  assign opcode = bus.In_Instr[31:26];
  assign funct  = bus.In_Instr[5:0];

  // Flush squashes any acceptance, so a dropped instruction never reaches the flag.
  assign accept = bus.In_Valid && in_ready && !bus.Flush;

  always_comb begin
    dec_imm     = 32'd0;
    dec_mode    = MODE_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      6'h00: begin
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) begin
          dec_imm  = {27'd0, bus.In_Instr[10:6]};
          dec_mode = MODE_SHAMT;
        end
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: begin
        dec_imm  = {{16{bus.In_Instr[15]}}, bus.In_Instr[15:0]};
        dec_mode = MODE_SIGN;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_imm  = {16'd0, bus.In_Instr[15:0]};
        dec_mode = MODE_ZERO;
      end
      6'h0F: begin
`ifdef IMM_EXT_UPPER_EN
        dec_imm  = {bus.In_Instr[15:0], 16'd0};
        dec_mode = MODE_UPPER;
`else
        // The ALU performs the lui shift in this build.
        dec_imm  = {16'd0, bus.In_Instr[15:0]};
        dec_mode = MODE_ZERO;
`endif
      end
      6'h02, 6'h03: begin
        dec_imm  = {6'd0, bus.In_Instr[25:0]};
        dec_mode = MODE_JUMP;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.Flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = FULL;
        FULL:    if (bus.Out_Ready && !accept) state_nxt = EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == FULL);
    // Held low through reset so nothing is offered as accepted before deassertion.
    in_ready  = Rst_n && (!out_valid || bus.Out_Ready);
  end

  // Payload only loads on acceptance; it is left untouched when EMPTY or stalled.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      imm_q  <= 32'd0;
      mode_q <= MODE_NONE;
    end else if (accept) begin
      imm_q  <= dec_imm;
      mode_q <= dec_mode;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      illegal_q <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Imm   = imm_q;
  assign bus.Out_Mode  = mode_q;
  assign bus.Illegal   = illegal_q;

endmodule

// File: tb/tb_imm_extend_ctrl.sv
// Directed-vector bench for imm_extend_ctrl; expected values are hand-computed constants.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
module tb_imm_extend_ctrl;

  logic Clk;
  logic Rst_n;
  int   n_vec;
  int   n_err;

  imm_extend_ctrl_if bus ();

  imm_extend_ctrl dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic ordy, input logic fl);
    bus.In_Valid  = vld;
    bus.In_Instr  = instr;
    bus.Out_Ready = ordy;
    bus.Flush     = fl;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Rst_n = 1'b0;
    drive(1'b1, 32'h2008FFF6, 1'b1, 1'b0);

    // Reset state, with an instruction offered that must not be accepted
    tick();
    tick();
    chk("rst_out_valid", {31'd0, bus.Out_Valid}, 32'd0);
    chk("rst_out_imm",   bus.Out_Imm,            32'd0);
    chk("rst_out_mode",  {29'd0, bus.Out_Mode},  32'd0);
    chk("rst_illegal",   {31'd0, bus.Illegal},   32'd0);
    chk("rst_in_ready",  {31'd0, bus.In_Ready},  32'd0);

    drive(1'b0, 32'h0, 1'b1, 1'b0);
    Rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.In_Ready}, 32'd1);

    // addi sign extension
    drive(1'b1, 32'h2008FFF6, 1'b1, 1'b0);
    tick();
    chk("addi_valid", {31'd0, bus.Out_Valid}, 32'd1);
    chk("addi_mode",  {29'd0, bus.Out_Mode},  32'd1);
    chk("addi_imm",   bus.Out_Imm,            32'hFFFFFFF6);

    // ori then lui back-to-back
    drive(1'b1, 32'h3508FFF6, 1'b1, 1'b0);
    tick();
    chk("ori_mode", {29'd0, bus.Out_Mode}, 32'd2);
    chk("ori_imm",  bus.Out_Imm,           32'h0000FFF6);
    drive(1'b1, 32'h3C081234, 1'b1, 1'b0);
    tick();
    chk("lui_valid", {31'd0, bus.Out_Valid}, 32'd1);
`ifdef IMM_EXT_UPPER_EN
    chk("lui_mode", {29'd0, bus.Out_Mode}, 32'd3);
    chk("lui_imm",  bus.Out_Imm,           32'h12340000);
`else
    chk("lui_mode", {29'd0, bus.Out_Mode}, 32'd2);
    chk("lui_imm",  bus.Out_Imm,           32'h00001234);
`endif

    // Assorted decodes: beq, bgez, xori, jal, sra, add (NONE, legal)
    drive(1'b1, 32'h1000FFFF, 1'b1, 1'b0);
    tick();
    chk("beq_imm", bus.Out_Imm, 32'hFFFFFFFF);
    drive(1'b1, 32'h04010005, 1'b1, 1'b0);
    tick();
    chk("bgez_mode", {29'd0, bus.Out_Mode}, 32'd1);
    chk("bgez_imm",  bus.Out_Imm,           32'h00000005);
    drive(1'b1, 32'h39088001, 1'b1, 1'b0);
    tick();
    chk("xori_imm", bus.Out_Imm, 32'h00008001);
    drive(1'b1, 32'h0E00ABCD, 1'b1, 1'b0);
    tick();
    chk("jal_mode", {29'd0, bus.Out_Mode}, 32'd5);
    chk("jal_imm",  bus.Out_Imm,           32'h0200ABCD);
    drive(1'b1, 32'h000847C3, 1'b1, 1'b0);
    tick();
    chk("sra_mode", {29'd0, bus.Out_Mode}, 32'd4);
    chk("sra_imm",  bus.Out_Imm,           32'h0000001F);
    drive(1'b1, 32'h01095020, 1'b1, 1'b0);
    tick();
    chk("add_mode",    {29'd0, bus.Out_Mode}, 32'd0);
    chk("add_imm",     bus.Out_Imm,           32'd0);
    chk("add_illegal", {31'd0, bus.Illegal},  32'd0);

    // Flush while an illegal opcode is offered: dropped, flag untouched
    drive(1'b1, 32'hFC001234, 1'b1, 1'b1);
    tick();
    chk("flush_drop_valid",   {31'd0, bus.Out_Valid}, 32'd0);
    chk("flush_drop_illegal", {31'd0, bus.Illegal},   32'd0);

    // sll held for three stalled cycles
    drive(1'b1, 32'h00084100, 1'b1, 1'b0);
    tick();
    chk("sll_mode", {29'd0, bus.Out_Mode}, 32'd4);
    chk("sll_imm",  bus.Out_Imm,           32'h4);
    drive(1'b1, 32'h2008FFF6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, bus.In_Ready}, 32'd0);
      tick();
      chk("stall_valid", {31'd0, bus.Out_Valid}, 32'd1);
      chk("stall_mode",  {29'd0, bus.Out_Mode},  32'd4);
      chk("stall_imm",   bus.Out_Imm,            32'h4);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("release_in_ready", {31'd0, bus.In_Ready}, 32'd1);
    tick();
    chk("release_valid", {31'd0, bus.Out_Valid}, 32'd0);
    chk("empty_imm_held", bus.Out_Imm, 32'h4);

    // Illegal opcode 0x3F
    drive(1'b1, 32'hFC001234, 1'b1, 1'b0);
    tick();
    chk("ill_valid",   {31'd0, bus.Out_Valid}, 32'd1);
    chk("ill_mode",    {29'd0, bus.Out_Mode},  32'd0);
    chk("ill_imm",     bus.Out_Imm,            32'd0);
    chk("ill_illegal", {31'd0, bus.Illegal},   32'd1);

    // Flush while FULL with j offered
    drive(1'b1, 32'h08000010, 1'b0, 1'b1);
    tick();
    chk("flush_full_valid",   {31'd0, bus.Out_Valid}, 32'd0);
    chk("flush_full_illegal", {31'd0, bus.Illegal},   32'd1);
    chk("flush_full_imm",     bus.Out_Imm,            32'd0);

    // j accepted afterwards; sticky flag remains
    drive(1'b1, 32'h08000010, 1'b0, 1'b0);
    tick();
    chk("j_mode",    {29'd0, bus.Out_Mode}, 32'd5);
    chk("j_imm",     bus.Out_Imm,           32'h00000010);
    chk("j_illegal", {31'd0, bus.Illegal},  32'd1);

    // Mid-cycle reset while FULL
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst_valid",    {31'd0, bus.Out_Valid}, 32'd0);
    chk("midrst_imm",      bus.Out_Imm,            32'd0);
    chk("midrst_mode",     {29'd0, bus.Out_Mode},  32'd0);
    chk("midrst_illegal",  {31'd0, bus.Illegal},   32'd0);
    chk("midrst_in_ready", {31'd0, bus.In_Ready},  32'd0);
    tick();
    Rst_n = 1'b1;
    tick();
    chk("after_rst_valid", {31'd0, bus.Out_Valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_ctrl.md
IMM_EXTEND_CTRL -- requirements
Module: imm_extend_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port In_Valid, input, 1: upstream (IF/ID) instruction valid.
REQ-004 SHALL have port In_Instr, input, 32: MIPS instruction word.
REQ-005 SHALL have port In_Ready, output, 1: stage can accept an instruction this cycle.
REQ-006 SHALL have port Flush, input, 1: synchronous discard of stage contents.
REQ-007 SHALL have port Out_Valid, output, 1: Out_Imm and Out_Mode hold a decoded instruction.
REQ-008 SHALL have port Out_Ready, input, 1: downstream (ID/EX) accepts this cycle.
REQ-009 SHALL have port Out_Imm, output, 32: extended immediate.
REQ-010 SHALL have port Out_Mode, output, 3: 0=NONE, 1=SIGN, 2=ZERO, 3=UPPER, 4=SHAMT, 5=JUMP.
REQ-011 SHALL have port Illegal, output, 1: sticky flag, set on acceptance of an undecodable opcode.

Function
REQ-012 SHALL implement a one-entry registered stage with two states: EMPTY (Out_Valid=0) and FULL (Out_Valid=1).
REQ-013 SHALL drive In_Ready = !Out_Valid || Out_Ready, combinationally, for full throughput.
REQ-014 SHALL accept the instruction when In_Valid && In_Ready, with results visible on Out_* the next cycle (latency 1).
REQ-015 SHALL transition EMPTY->FULL on accept, FULL->EMPTY on Out_Ready with no accept, and stay FULL on simultaneous Out_Ready and accept, loading the new entry.
REQ-016 SHALL hold Out_Imm and Out_Mode stable while FULL && !Out_Ready.
REQ-017 SHALL decode opcode In_Instr[31:26] as SIGN {{16{i[15]}},i[15:0]} for 0x01, 0x04-0x0B, 0x20, 0x21, 0x23, 0x28, 0x29, 0x2B.
REQ-018 SHALL decode as ZERO {16'b0,i[15:0]} for 0x0C-0x0E.
REQ-019 SHALL decode as UPPER {i[15:0],16'b0} for 0x0F.
REQ-020 SHALL decode as JUMP {6'b0,i[25:0]} for 0x02-0x03.
REQ-021 SHALL decode opcode 0x00 as SHAMT {27'b0,i[10:6]} when funct i[5:0] is 0x00, 0x02 or 0x03, and as NONE with Out_Imm=0 otherwise.
REQ-022 SHALL treat any other opcode as NONE, Out_Imm=0, and set Illegal on acceptance.
REQ-023 SHALL give Flush priority over everything: next cycle EMPTY, and an instruction presented in the Flush cycle is dropped and does not set Illegal.
REQ-024 SHALL leave Out_Imm/Out_Mode unchanged when EMPTY; consumers qualify them with Out_Valid.

Reset
REQ-025 SHALL force, while Rst_n=0 and immediately without waiting for a clock edge: state EMPTY, Out_Valid=0, Out_Imm=0, Out_Mode=0, Illegal=0.
REQ-026 SHALL not accept during reset (In_Ready=1 only after deassertion), and SHALL lose an in-flight entry on mid-operation reset without output.
REQ-027 SHALL clear Illegal only on reset; Flush does not clear it.

Configuration
REQ-028 SHALL, with IMM_EXT_UPPER_EN defined, decode opcode 0x0F as UPPER per REQ-019.
REQ-029 SHALL, without IMM_EXT_UPPER_EN defined, decode opcode 0x0F as ZERO (lui immediate shifted in ALU), and never emit Out_Mode=3.

Verification
REQ-030 SHALL pass: addi imm 0xFFF6 (0x2008FFF6), Out_Ready=1 -> next cycle Out_Valid=1, Out_Mode=1, Out_Imm=0xFFFFFFF6.
REQ-031 SHALL pass: ori 0x3508FFF6 then lui 0x3C081234 back-to-back -> Out_Imm=0x0000FFF6 (ZERO), then 0x12340000 (UPPER), or 0x00001234 (ZERO) without IMM_EXT_UPPER_EN.
REQ-032 SHALL pass: sll 0x00084100 (shamt 4), Out_Ready held 0 for 3 cycles -> Out_Mode=4, Out_Imm=0x4 stable, In_Ready=0 for those cycles, releases on Out_Ready=1.
REQ-033 SHALL pass: opcode 0x3F accepted -> Out_Mode=0, Out_Imm=0, Illegal=1 persisting through a following Flush and cleared only by Rst_n=0.
REQ-034 SHALL pass: Flush asserted with In_Valid=1 (j 0x08000010) while FULL -> next cycle Out_Valid=0, Illegal unchanged.
REQ-035 SHALL pass: Rst_n dropped mid-cycle while FULL -> Out_Valid=0 and Out_Imm=0 before the next Clk edge.
